// File: rtl/route_lookup_sched.sv
// Round-robin front end that time-shares one combinational route unit.
// Holds each key for a fixed evaluation window, then returns the direction.
module route_lookup_sched #(
    parameter int NREQ     = 4,
    parameter int KEY_W    = 60,
    parameter int DIR_W    = 3,
    parameter int EVAL_CYC = 2,
    localparam int IDW     = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*KEY_W-1:0] req_key,
    output logic [NREQ-1:0]       req_ready,
    output logic [KEY_W-1:0]      rl_key,
    input  logic [DIR_W-1:0]      rl_dir,
    output logic                  rsp_valid,
    output logic [IDW-1:0]        rsp_id,
    output logic [DIR_W-1:0]      rsp_dir,
    input  logic                  rsp_ready,
    output logic                  busy,
    output logic [15:0]           lookup_cnt
);

    localparam int CW = (EVAL_CYC > 1) ? $clog2(EVAL_CYC) : 1;

    typedef enum logic [1:0] {
        IDLE,
        EVAL,
        RESP
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] idx;
    logic [IDW-1:0] gnt_idx;
    logic           gnt_any;
    logic           grant;
    logic [CW-1:0]  evcnt;
    logic [15:0]    cnt_q;

    assign lookup_cnt = cnt_q;

    // NREQ is a power of two, so the IDW-bit sum wraps the search for free.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        idx     = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = ptr + IDW'(k);
            if (!gnt_any && req_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = idx;
            end
        end
    end

    assign grant     = (state == IDLE) && gnt_any && !rst;
    assign req_ready = grant ? (NREQ'(1) << gnt_idx) : '0;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant) state_nxt = EVAL;
            EVAL:    if (evcnt == '0) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            evcnt     <= '0;
            rl_key    <= '0;
            rsp_id    <= '0;
            rsp_dir   <= '0;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state     <= state_nxt;
            busy      <= (state_nxt != IDLE);
            rsp_valid <= (state_nxt == RESP);
            if (grant) begin
                rl_key <= req_key[gnt_idx*KEY_W +: KEY_W];
                rsp_id <= gnt_idx;
                ptr    <= gnt_idx + IDW'(1);
                evcnt  <= CW'(EVAL_CYC - 1);
            end
            if (state == EVAL) begin
                if (evcnt != '0) evcnt <= evcnt - CW'(1);
                else rsp_dir <= rl_dir;
            end
            if (state == RESP && rsp_ready) cnt_q <= cnt_q + 16'd1;
        end
    end

endmodule

// File: doc/route_lookup_sched.md
# route_lookup_sched

Round-robin scheduler that shares one combinational route-decision unit among `NREQ` requesting input ports. It accepts a lookup key from one requester at a time and drives it to the shared unit. It holds the key stable for a fixed multicycle evaluation window, then captures the direction code. The result is returned with its requester ID over a valid/ready response channel. The block sits between the per-port header parsers and the route-decision logic.

## Interface
- `NREQ`, 4: number of requesters; must be ≥2 and a power of two.
- `KEY_W`, 60: lookup key width, which is the route unit's input width.
- `DIR_W`, 3: direction code width, which is the route unit's output width.
- `EVAL_CYC`, 2: cycles the key is held before the result is sampled; must be ≥1.
- `clk`  in  1  sole clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NREQ  per-requester lookup request.
- `req_key`  in  NREQ*KEY_W  packed keys; requester i occupies bits [i*KEY_W +: KEY_W].
- `req_ready`  out  NREQ  one-hot accept strobe.
- `rl_key`  out  KEY_W  registered key driven to the route unit.
- `rl_dir`  in  DIR_W  route unit result; combinational function of `rl_key`.
- `rsp_valid`  out  1  response available.
- `rsp_id`  out  log2(NREQ)  index of the requester that issued the lookup.
- `rsp_dir`  out  DIR_W  captured direction code.
- `rsp_ready`  in  1  response consumer accept.
- `busy`  out  1  high in any state other than IDLE.
- `lookup_cnt`  out  16  count of completed responses; wraps modulo 2^16.

## Operation
- The FSM has three states: IDLE, EVAL and RESP. There is one lookup in flight at most.
- **IDLE**
  - Grant g is the first index with `req_valid` high, searching from `ptr` upward and wrapping modulo NREQ.
  - `req_ready[g]` is asserted combinationally. All other `req_ready` bits are 0.
  - If no request is valid, `req_ready` is all zeros.
  - On a grant cycle, the block registers `rl_key` ← key of g and `rsp_id` ← g.
  - On a grant cycle, it also loads `ptr` ← (g+1) mod NREQ and `evcnt` ← EVAL_CYC−1, then moves to EVAL.
- **EVAL**
  - `rl_key` is held.
  - While `evcnt` ≠ 0, the block decrements it.
  - When `evcnt` = 0, it registers `rsp_dir` ← `rl_dir` and moves to RESP.
- **RESP**
  - `rsp_valid` = 1. `rsp_id`, `rsp_dir` and `rl_key` are held stable.
  - When `rsp_ready` is high, `lookup_cnt` increments (0xFFFF → 0x0000) and the FSM returns to IDLE.
  - No request is accepted in RESP. The next grant can occur in the IDLE cycle that follows.
- `req_ready` is 0 in EVAL and RESP regardless of `req_valid`.
- Requester obligations: each requester holds `req_valid` and its key until it sees `req_ready`. A requester that deasserts `req_valid` before grant loses nothing; it is simply skipped.
- Arbitration is fair: under continuous requests from all ports, grants follow the order ptr, ptr+1, …, with no port skipped.
- Reset in any state takes effect on the next edge. The in-flight lookup is dropped with no response.
- Reset values: state = IDLE, `ptr` = 0, `rl_key` = 0, `rsp_id` = 0, `rsp_dir` = 0, `rsp_valid` = 0, `req_ready` = 0, `busy` = 0, `lookup_cnt` = 0.

## Timing
- Grant handshake at cycle t:
  - Cycles t+1 … t+EVAL_CYC are EVAL.
  - `rl_dir` is sampled at the end of cycle t+EVAL_CYC.
  - `rsp_valid` rises in cycle t+EVAL_CYC+1.
- Minimum lookup period is EVAL_CYC+2 cycles (grant, EVAL_CYC cycles, 1 RESP cycle with `rsp_ready` high).
- `rl_key` is guaranteed stable from t+1 until the cycle after the response handshake. This covers the route unit's multicycle path constraint of EVAL_CYC cycles.
- `busy`, `rsp_valid` and `rl_key` are registered outputs.
- `req_ready` is combinational from `req_valid`, state and `ptr`. There is no combinational path from `rsp_ready` to `req_ready`.

## Test plan
- **Reset:** hold `rst` for 3 cycles with random inputs → all outputs 0 and `req_ready` = 0 throughout; first IDLE cycle after release grants index 0 if `req_valid` = 4'b1111.
- **Single lookup:** NREQ=4, EVAL_CYC=2; `req_valid`=4'b0100 at cycle 10, key 60'h0A5…, route model returns 3'b101 → `req_ready`=4'b0100 at 10; `rsp_valid` at 13 with `rsp_id`=2, `rsp_dir`=3'b101; `rsp_ready` high at 13 → `lookup_cnt`=1 at 14.
- **Round robin:** all four requesters valid continuously with `rsp_ready`=1 → grant order 0,1,2,3,0,1; one grant every 4 cycles; each `rsp_id` matches the corresponding grant.
- **Backpressure:** `rsp_ready` low for 5 cycles in RESP → `rsp_valid`, `rsp_id`, `rsp_dir` and `rl_key` stable; `req_ready` stays 0; the response completes on the cycle `rsp_ready` rises.
- **Reset mid-lookup:** assert `rst` in the second EVAL cycle → next cycle IDLE, `rsp_valid` never asserts for that lookup, `ptr`=0.
- **Counter wrap:** preload 65535 completed responses (or force `lookup_cnt`=16'hFFFF) and complete one more → `lookup_cnt`=16'h0000.
